// File: rtl/sio_uart_rx_pkg.sv
// Shared definitions for the SIO serial receive path.
// Holds the receiver state encodings and the default oversampling ratio,
// which must match the ratio of the upstream SIO clock divider.
// No ports; imported by sio_uart_rx and its sub-modules.
package sio_uart_rx_pkg;

    // Receiver frame states. RX_PARITY is only reachable when the
    // receiver is built with SIO_RX_PARITY_EN defined.
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // sio_clk periods per serial bit (4x baud from the divider).
    localparam int SIO_OSR_DEFAULT = 4;

endpackage

// File: rtl/sio_uart_rx_sync_edge.sv
// Two-flop synchroniser for a single asynchronous input, with an optional
// rising-edge pulse taken from the synchronised value.
// Ports:
//   clk    in   system clock
//   n_rst  in   asynchronous reset, active-low
//   d      in   asynchronous input
//   q      out  synchronised copy of d (2 clk latency)
//   rise   out  1-clk pulse when q goes 0->1 (constant 0 when EDGE_EN=0)
// Parameters:
//   RST_VAL  value loaded into every flop during reset
//   EDGE_EN  1 = generate the rise pulse
module sio_uart_rx_sync_edge #(
    parameter logic RST_VAL = 1'b0,
    parameter bit   EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q;
    assign rise = EDGE_EN ? (sync_q & ~prev_q) : 1'b0;

endmodule

// File: rtl/sio_uart_rx.sv
// Serial receiver for asynchronous frames on rxd (start, DATA_BITS data
// LSB first, optional even parity, one stop bit). sio_clk from the SIO
// divider is synchronised and used only as an oversampling enable; all
// state lives in the clk domain. Received bytes are offered through a
// valid/ready holding register.
//
// Handshake: rx_data is valid while rx_valid=1; a byte is consumed on any
// clk edge where rx_valid & rx_ready are both 1. A byte that completes on
// the same edge as a consume replaces the consumed one.
//
// Build option: define SIO_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit and to enable parity_err.
//
// Ports:
//   clk, n_rst   system clock, asynchronous active-low reset
//   sio_clk      OSR x baud oversample clock (async, synchronised here)
//   rxd          serial input, idle high (async, synchronised here)
//   rx_data      received byte, valid while rx_valid=1
//   rx_valid     holding register full
//   rx_ready     consumer accepts rx_data when rx_valid & rx_ready
//   frame_err    1-clk pulse: stop bit sampled low
//   overrun      1-clk pulse: byte completed while holding register full
//   parity_err   1-clk pulse: parity mismatch (0 without SIO_RX_PARITY_EN)
module sio_uart_rx
    import sio_uart_rx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int OSR          = SIO_OSR_DEFAULT,
    parameter int SAMPLE_PHASE = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 sio_clk,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int PH_W = $clog2(OSR);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [PH_W-1:0] SAMPLE_PH = PH_W'(SAMPLE_PHASE);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_BITS - 1);

    logic tick;
    logic rxd_s;
    logic sio_s_unused;
    logic rxd_edge_unused;

    sio_uart_rx_sync_edge #(
        .RST_VAL (1'b0),
        .EDGE_EN (1'b1)
    ) u_tick_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (sio_clk),
        .q     (sio_s_unused),
        .rise  (tick)
    );

    sio_uart_rx_sync_edge #(
        .RST_VAL (1'b1),
        .EDGE_EN (1'b0)
    ) u_rxd_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (rxd),
        .q     (rxd_s),
        .rise  (rxd_edge_unused)
    );

    rx_state_e             state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  sample;
    logic                  complete;
`ifdef SIO_RX_PARITY_EN
    logic                  par_bit_q, par_bit_d;
    logic                  parity_err_q, parity_err_d;
    logic                  par_bad;

    // Even parity: data bits plus parity bit must hold an even count of ones.
    assign par_bad = ^{shift_q, par_bit_q};
`endif

    // Phase counts ticks since start detection; the first sample lands two
    // ticks after detection, i.e. mid-bit for OSR=4, SAMPLE_PHASE=1.
    assign sample = (phase_q == SAMPLE_PH);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        complete    = 1'b0;
`ifdef SIO_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        if (tick) begin
            case (state_q)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        state_d = RX_START;
                        phase_d = '0;
                    end
                end
                RX_START: begin
                    phase_d = phase_q + PH_W'(1);
                    if (sample) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        state_d   = rxd_s ? RX_IDLE : RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    phase_d = phase_q + PH_W'(1);
                    if (sample) begin
                        shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef SIO_RX_PARITY_EN
                            state_d = RX_PARITY;
`else
                            state_d = RX_STOP;
`endif
                        end
                    end
                end
`ifdef SIO_RX_PARITY_EN
                RX_PARITY: begin
                    phase_d = phase_q + PH_W'(1);
                    if (sample) begin
                        par_bit_d = rxd_s;
                        state_d   = RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    phase_d = phase_q + PH_W'(1);
                    if (sample) begin
                        // Return to IDLE on the sample tick so a start bit
                        // right after the stop bit is seen from the next tick.
                        state_d = RX_IDLE;
                        // A bad stop bit masks any parity result.
                        if (!rxd_s)
                            frame_err_d = 1'b1;
`ifdef SIO_RX_PARITY_EN
                        else if (par_bad)
                            parity_err_d = 1'b1;
`endif
                        else
                            complete = 1'b1;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end

        if (complete) begin
            // A consume on this same edge frees the register for the new byte.
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q_next(shift_d);
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // The completed byte is fully shifted before the stop state, so the
    // current shift contents are the byte; this keeps that explicit.
    function automatic logic [DATA_BITS-1:0] shift_q_next(input logic [DATA_BITS-1:0] v);
        return v;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= RX_IDLE;
            phase_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIO_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef SIO_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef SIO_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sio_uart_rx.sv
`timescale 1ns/1ps
module tb_sio_uart_rx;

    logic       clk;
    logic       n_rst;
    logic       sio_clk;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int total = 0;
    int bad   = 0;

    // Scoreboard: bytes expected to be consumed, pushed as frames are driven.
    logic [7:0] exp_q[$];
    // Bytes observed crossing the valid/ready handshake (written by monitor only).
    logic [7:0] got_mem[0:63];
    int         got_n  = 0;
    int         got_rd = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;

    sio_uart_rx #(
        .DATA_BITS    (8),
        .OSR          (4),
        .SAMPLE_PHASE (1)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sio_clk    (sio_clk),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sio_clk: 5 clk high, 5 clk low, changing on clk falling edges.
    initial begin
        sio_clk = 1'b0;
        forever begin
            repeat (5) @(negedge clk);
            sio_clk = ~sio_clk;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        #1;
        if (rx_valid && rx_ready) begin
            if (got_n < 64) got_mem[got_n] = rx_data;
            got_n = got_n + 1;
        end
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (overrun)    ov_cnt = ov_cnt + 1;
        if (parity_err) pe_cnt = pe_cnt + 1;
    end

    // ---------------- drivers ----------------
    // One serial bit = 4 sio_clk periods, changing on a sio_clk rising edge.
    task automatic drive_bit(input logic b);
        @(posedge sio_clk);
        rxd = b;
        repeat (3) @(posedge sio_clk);
    endtask

    task automatic idle_edges(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge sio_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SIO_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_b);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00)   begin bad++; $display("FAIL reset_data got=%0h exp=00", rx_data); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%0b exp=0", parity_err); end
    endtask

    task automatic test_basic_a5();
        logic [7:0] d;
        logic [7:0] e;
        int n;
        bit seen;
        d = 8'hA5;
        exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SIO_RX_PARITY_EN
        drive_bit(^d);
`endif
        @(posedge sio_clk);
        rxd = 1'b1;
        repeat (2) @(posedge sio_clk);
        // This is the stop-sample sio_clk edge. tick is high during the 2nd
        // clk after it (2-flop sync + edge), rx_valid one clk later: 3 negedges.
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (rx_valid) seen = 1;
        end
        total++; if (n != 3)          begin bad++; $display("FAIL a5_latency got=%0d exp=3", n); end
        total++; if (rx_data !== d)   begin bad++; $display("FAIL a5_data got=%0h exp=%0h", rx_data, d); end
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL a5_valid_width got=%0b exp=0", rx_valid); end
        @(posedge sio_clk);
        idle_edges(4);
        total++;
        if (got_n - got_rd != exp_q.size()) begin
            bad++; $display("FAIL a5_count got=%0d exp=%0d", got_n - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_n) begin
            e = exp_q.pop_front();
            total++; if (got_mem[got_rd] !== e) begin bad++; $display("FAIL a5_sb got=%0h exp=%0h", got_mem[got_rd], e); end
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_n;
    endtask

    task automatic test_glitch();
        int g0, f0, o0, p0;
        g0 = got_n; f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
        @(posedge sio_clk);
        rxd = 1'b0;
        @(posedge sio_clk);
        rxd = 1'b1;
        repeat (12) @(posedge sio_clk);
        total++; if (got_n != g0)     begin bad++; $display("FAIL glitch_rx got=%0d exp=%0d", got_n, g0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%0b exp=0", rx_valid); end
        total++; if (fe_cnt != f0)    begin bad++; $display("FAIL glitch_fe got=%0d exp=%0d", fe_cnt, f0); end
        total++; if (ov_cnt != o0)    begin bad++; $display("FAIL glitch_ov got=%0d exp=%0d", ov_cnt, o0); end
        total++; if (pe_cnt != p0)    begin bad++; $display("FAIL glitch_pe got=%0d exp=%0d", pe_cnt, p0); end
    endtask

    task automatic test_frame_err();
        int g0, f0, o0, p0;
        logic [7:0] e;
        g0 = got_n; f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
        send_frame(8'h3C, 1'b0);
        idle_edges(8);
        total++; if (fe_cnt - f0 != 1)  begin bad++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - f0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ferr_valid got=%0b exp=0", rx_valid); end
        total++; if (got_n != g0)       begin bad++; $display("FAIL ferr_rx got=%0d exp=%0d", got_n, g0); end
        total++; if (ov_cnt != o0 || pe_cnt != p0) begin bad++; $display("FAIL ferr_other got=%0d exp=0", (ov_cnt - o0) + (pe_cnt - p0)); end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle_edges(4);
        total++; if (fe_cnt - f0 != 1)  begin bad++; $display("FAIL ferr_recover_fe got=%0d exp=1", fe_cnt - f0); end
        total++;
        if (got_n - got_rd != exp_q.size()) begin
            bad++; $display("FAIL ferr_count got=%0d exp=%0d", got_n - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_n) begin
            e = exp_q.pop_front();
            total++; if (got_mem[got_rd] !== e) begin bad++; $display("FAIL ferr_sb got=%0h exp=%0h", got_mem[got_rd], e); end
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_n;
    endtask

    task automatic test_back_to_back();
        int o0, f0;
        logic [7:0] e;
        o0 = ov_cnt; f0 = fe_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%0b exp=1", rx_valid); end
        send_frame(8'h22, 1'b1);
        idle_edges(4);
        total++; if (ov_cnt - o0 != 1)  begin bad++; $display("FAIL b2b_overrun got=%0d exp=1", ov_cnt - o0); end
        total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL b2b_held_data got=%0h exp=11", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_held_valid got=%0b exp=1", rx_valid); end
        total++; if (fe_cnt != f0)      begin bad++; $display("FAIL b2b_fe got=%0d exp=%0d", fe_cnt, f0); end
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%0b exp=0", rx_valid); end
        idle_edges(2);
        total++;
        if (got_n - got_rd != exp_q.size()) begin
            bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_n - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_n) begin
            e = exp_q.pop_front();
            total++; if (got_mem[got_rd] !== e) begin bad++; $display("FAIL b2b_sb got=%0h exp=%0h", got_mem[got_rd], e); end
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_n;
    endtask

    task automatic test_parity();
        int p0, f0, g0;
        logic [7:0] e;
        p0 = pe_cnt; f0 = fe_cnt; g0 = got_n;
`ifdef SIO_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1, so 0 is a mismatch.
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(e_bit(8'h07, i));
        drive_bit(1'b0);
        drive_bit(1'b1);
        idle_edges(4);
        total++; if (pe_cnt - p0 != 1)  begin bad++; $display("FAIL par_err_pulse got=%0d exp=1", pe_cnt - p0); end
        total++; if (fe_cnt != f0)      begin bad++; $display("FAIL par_err_fe got=%0d exp=%0d", fe_cnt, f0); end
        total++; if (got_n != g0)       begin bad++; $display("FAIL par_err_rx got=%0d exp=%0d", got_n, g0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL par_err_valid got=%0b exp=0", rx_valid); end
        // Bad parity and bad stop together: only the framing error shows.
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(e_bit(8'h07, i));
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle_edges(8);
        total++; if (pe_cnt - p0 != 1)  begin bad++; $display("FAIL par_stop_pe got=%0d exp=1", pe_cnt - p0); end
        total++; if (fe_cnt - f0 != 1)  begin bad++; $display("FAIL par_stop_fe got=%0d exp=1", fe_cnt - f0); end
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        idle_edges(4);
        total++; if (pe_cnt - p0 != 1)  begin bad++; $display("FAIL par_ok_pe got=%0d exp=1", pe_cnt - p0); end
`else
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        idle_edges(4);
        total++; if (pe_cnt != p0)      begin bad++; $display("FAIL nopar_pe got=%0d exp=%0d", pe_cnt, p0); end
        total++; if (fe_cnt != f0)      begin bad++; $display("FAIL nopar_fe got=%0d exp=%0d", fe_cnt, f0); end
`endif
        total++;
        if (got_n - got_rd != exp_q.size()) begin
            bad++; $display("FAIL par_count got=%0d exp=%0d", got_n - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_n) begin
            e = exp_q.pop_front();
            total++; if (got_mem[got_rd] !== e) begin bad++; $display("FAIL par_sb got=%0h exp=%0h", got_mem[got_rd], e); end
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_n;
    endtask

    function automatic logic e_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

    task automatic test_random();
        int f0, o0;
        logic [7:0] b;
        logic [7:0] e;
        f0 = fe_cnt; o0 = ov_cnt;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        idle_edges(4);
        total++; if (fe_cnt != f0 || ov_cnt != o0) begin bad++; $display("FAIL rand_errors got=%0d exp=0", (fe_cnt - f0) + (ov_cnt - o0)); end
        total++;
        if (got_n - got_rd != exp_q.size()) begin
            bad++; $display("FAIL rand_count got=%0d exp=%0d", got_n - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_n) begin
            e = exp_q.pop_front();
            total++; if (got_mem[got_rd] !== e) begin bad++; $display("FAIL rand_sb got=%0h exp=%0h", got_mem[got_rd], e); end
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_n;
    endtask

    task automatic test_reset_mid_frame();
        int f0, o0, p0;
        logic [7:0] e;
        rx_ready = 1'b0;
        send_frame(8'hC3, 1'b1);
        idle_edges(2);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0b exp=1", rx_valid); end
        total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL rst_pre_data got=%0h exp=c3", rx_data); end
        f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%0h exp=00", rx_data); end
        rxd = 1'b1;
        n_rst = 1'b1;
        idle_edges(12);
        total++; if (fe_cnt != f0 || ov_cnt != o0 || pe_cnt != p0) begin
            bad++; $display("FAIL rst_mid_flags got=%0d exp=0", (fe_cnt - f0) + (ov_cnt - o0) + (pe_cnt - p0));
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_after_valid got=%0b exp=0", rx_valid); end
        rx_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle_edges(4);
        total++;
        if (got_n - got_rd != exp_q.size()) begin
            bad++; $display("FAIL rst_count got=%0d exp=%0d", got_n - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_n) begin
            e = exp_q.pop_front();
            total++; if (got_mem[got_rd] !== e) begin bad++; $display("FAIL rst_sb got=%0h exp=%0h", got_mem[got_rd], e); end
            got_rd++;
        end
        exp_q.delete();
        got_rd = got_n;
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_rst    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        n_rst = 1'b1;
        idle_edges(4);
        test_basic_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_parity();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
